// File: rtl/pipe_register.sv
`default_nettype none
// ============================================================================
// Module      : pipe_register
// Description : DEPTH-stage, N-bit register pipeline with valid/ready
//               handshakes on both sides. Stalls back-propagate through a
//               combinational ready chain and empty stages (bubbles) always
//               accept, so gaps close up toward the output while it is stalled.
//               Optional registered occupancy counter on port `count`,
//               enabled by defining the macro PIPE_REG_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_register #(
    parameter int N     = 8,
    parameter int DEPTH = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N-1:0]                  I,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N-1:0]                  Q
`ifdef PIPE_REG_COUNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]    count
`endif
);

    // Stage storage: index 0 is the input side, DEPTH-1 drives Q.
    logic [DEPTH-1:0]          valid_q;
    logic [DEPTH-1:0]          valid_d;
    logic [DEPTH-1:0][N-1:0]   data_q;
    logic [DEPTH-1:0][N-1:0]   data_d;

    // Per-stage ready: a stage can load when it, or anything downstream of it,
    // has a free slot, or when the output is being drained this cycle.
    logic [DEPTH-1:0]          w_rdy;
    logic                      w_in_xfer;

    // Expressed as a reduction over the downstream valids rather than a
    // recursive chain so no vector bit depends on another bit of itself.
    for (genvar k = 0; k < DEPTH; k++) begin : g_rdy
        assign w_rdy[k] = out_ready | ~(&valid_q[DEPTH-1:k]);
    end

    assign in_ready  = w_rdy[0] & ~flush;
    assign w_in_xfer = in_valid & in_ready;
    assign out_valid = valid_q[DEPTH-1];
    assign Q         = data_q[DEPTH-1];

    // Next-state for every stage: shift from upstream when ready, else hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            // Drop every word in flight; data registers keep their contents.
            valid_d = '0;
        end else begin
            if (w_rdy[0]) begin
                valid_d[0] = w_in_xfer;
                if (w_in_xfer) begin
                    data_d[0] = I;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (w_rdy[k]) begin
                    valid_d[k] = valid_q[k-1];
                    if (valid_q[k-1]) begin
                        data_d[k] = data_q[k-1];
                    end
                end
            end
        end
    end

    // Stage registers with synchronous reset clearing data and valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

`ifdef PIPE_REG_COUNT_EN
    localparam int CNT_W = $clog2(DEPTH+1);

    logic              w_out_xfer;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    assign w_out_xfer = out_valid & out_ready;
    assign count      = count_q;

    // Occupancy tracks accepted minus delivered words; flush empties it.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            count_d = count_q + CNT_W'(1);
        end else if (!w_in_xfer && w_out_xfer) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Occupancy counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_register
// Description : Directed self-checking bench for pipe_register (N=8, DEPTH=3).
//               Occupancy checks are compiled in when PIPE_REG_COUNT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_register;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] I;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Q;
`ifdef PIPE_REG_COUNT_EN
    logic [1:0] count;
`endif

    int tests;
    int fails;

    pipe_register #(.N(8), .DEPTH(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .I         (I),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q)
`ifdef PIPE_REG_COUNT_EN
        ,
        .count     (count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PIPE_REG_COUNT_EN
    // Occupancy must equal the number of set stage valid bits every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            tests++;
            if (count !== 2'($countones(dut.valid_q))) begin
                fails++;
                $display("FAIL count_vs_valid: count=%0d valid=%b", count, dut.valid_q);
            end
        end
    end
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; I = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++;
        if (Q !== 8'h00) begin fails++; $display("FAIL reset_Q: got %h want 00", Q); end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef PIPE_REG_COUNT_EN
        tests++;
        if (count !== 2'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
`endif
    endtask

    task automatic test_streaming();
        int got;
        logic [7:0] exp;
        got = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            in_valid = (c < 10);
            I = 8'(c + 1);
            #1;
            if (c < 10) begin
                tests++;
                if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready c=%0d: got %b want 1", c, in_ready); end
            end
            if (c == 2) begin
                tests++;
                if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_early_valid: got %b want 0", out_valid); end
            end
            if (c == 3) begin
                tests++;
                if (out_valid !== 1'b1 || Q !== 8'h01) begin
                    fails++; $display("FAIL stream_latency: got valid=%b Q=%h want 1/01", out_valid, Q);
                end
            end
            if (out_valid === 1'b1) begin
                exp = 8'(got + 1);
                tests++;
                if (Q !== exp) begin fails++; $display("FAIL stream_data #%0d: got %h want %h", got, Q, exp); end
                got++;
            end
            tick();
        end
        in_valid = 1'b0;
        tests++;
        if (got != 10) begin fails++; $display("FAIL stream_count: got %0d words want 10", got); end
    endtask

    task automatic test_backpressure();
        int got;
        logic [7:0] exp;
        logic acc;
        got = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            I = 8'hA1 + 8'(i);
            #1;
            tests++;
            if (in_ready !== (i < 3)) begin
                fails++; $display("FAIL bp_in_ready offer %0d: got %b want %b", i, in_ready, (i < 3));
            end
            if (i < 3) tick();
        end
`ifdef PIPE_REG_COUNT_EN
        tests++;
        if (count !== 2'd3) begin fails++; $display("FAIL bp_count: got %0d want 3", count); end
`endif
        tick();
        tests++;
        if (out_valid !== 1'b1 || Q !== 8'hA1) begin
            fails++; $display("FAIL bp_hold: got valid=%b Q=%h want 1/A1", out_valid, Q);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (out_valid === 1'b1) begin
                exp = 8'hA1 + 8'(got);
                tests++;
                if (Q !== exp) begin fails++; $display("FAIL bp_data #%0d: got %h want %h", got, Q, exp); end
                got++;
            end
            acc = in_valid & in_ready;
            tick();
            if (acc) in_valid = 1'b0;
        end
        tests++;
        if (got != 4) begin fails++; $display("FAIL bp_count_out: got %0d words want 4", got); end
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        in_valid = 1'b1; I = 8'h11;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL bubble_accept1: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1; I = 8'h22;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL bubble_accept2: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        tick();
        tests++;
        if (dut.valid_q !== 3'b110) begin fails++; $display("FAIL bubble_compact: got %b want 110", dut.valid_q); end
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || Q !== 8'h11) begin
            fails++; $display("FAIL bubble_state: got rdy=%b valid=%b Q=%h want 1/1/11", in_ready, out_valid, Q);
        end
        out_ready = 1'b1;
        tick();
        tests++;
        if (out_valid !== 1'b1 || Q !== 8'h22) begin
            fails++; $display("FAIL bubble_drain: got valid=%b Q=%h want 1/22", out_valid, Q);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL bubble_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_full_simul();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; I = 8'h31 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        out_ready = 1'b1; in_valid = 1'b1; I = 8'h34;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || Q !== 8'h31) begin
            fails++; $display("FAIL full_simul_pre: got rdy=%b valid=%b Q=%h want 1/1/31", in_ready, out_valid, Q);
        end
        tick();
        in_valid = 1'b0;
        tests++;
        if (dut.valid_q !== 3'b111 || Q !== 8'h32) begin
            fails++; $display("FAIL full_simul_post: got valid=%b Q=%h want 111/32", dut.valid_q, Q);
        end
`ifdef PIPE_REG_COUNT_EN
        tests++;
        if (count !== 2'd3) begin fails++; $display("FAIL full_simul_count: got %0d want 3", count); end
`endif
        tick();
        tests++;
        if (Q !== 8'h33) begin fails++; $display("FAIL full_drain33: got %h want 33", Q); end
        tick();
        tests++;
        if (out_valid !== 1'b1 || Q !== 8'h34) begin
            fails++; $display("FAIL full_drain34: got valid=%b Q=%h want 1/34", out_valid, Q);
        end
        tick();
    endtask

    task automatic test_flush();
        int bad;
        bad = 0;
        out_ready = 1'b0;
        in_valid = 1'b1; I = 8'h41; tick();
        I = 8'h42; tick();
        flush = 1'b1; in_valid = 1'b1; I = 8'h55;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || dut.valid_q !== 3'b000) begin
            fails++; $display("FAIL flush_cleared: got valid=%b stages=%b want 0/000", out_valid, dut.valid_q);
        end
`ifdef PIPE_REG_COUNT_EN
        tests++;
        if (count !== 2'd0) begin fails++; $display("FAIL flush_count: got %0d want 0", count); end
`endif
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (out_valid === 1'b1) bad++;
            tick();
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL flush_leak: got %0d valid outputs want 0", bad); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; I = 8'h61 + 8'(i);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || Q !== 8'h00 || in_ready !== 1'b1) begin
            fails++; $display("FAIL rstmid_state: got valid=%b Q=%h rdy=%b want 0/00/1", out_valid, Q, in_ready);
        end
`ifdef PIPE_REG_COUNT_EN
        tests++;
        if (count !== 2'd0) begin fails++; $display("FAIL rstmid_count: got %0d want 0", count); end
`endif
        in_valid = 1'b1; I = 8'h77;
        tick();
        in_valid = 1'b0;
        tick();
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_early: got %b want 0", out_valid); end
        tick();
        tests++;
        if (out_valid !== 1'b1 || Q !== 8'h77) begin
            fails++; $display("FAIL rstmid_latency: got valid=%b Q=%h want 1/77", out_valid, Q);
        end
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; I = 8'h00;
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble();
        test_full_simul();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
